// File: rtl/imem_loader.sv
// Byte-serial program loader for the instruction memory: packs four bytes big-endian
// per word, writes words from address 0 upward and holds the CPU until a load completes.
module imem_loader #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        FINISH
    } state_t;

    localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       shreg;
    logic              accept;
    logic              last_word;

    // Requests larger than the memory are clamped so the address never wraps.
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] wc);
        return (wc > CAP) ? CAP : wc;
    endfunction

    assign accept       = in_valid && (state == ASSEMBLE);
    assign word_cnt_inc = word_cnt + CNT_ONE;
    assign last_word    = (word_cnt_inc == cnt);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count != '0) ? ASSEMBLE : FINISH;
                end
            end
            ASSEMBLE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (byte_idx == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                imem_we   = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? FINISH : ASSEMBLE;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            word_cnt   <= '0;
            cnt        <= '0;
            shreg      <= 32'd0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            cnt       <= clamp_count(word_count);
                            word_cnt  <= '0;
                            byte_idx  <= 2'd0;
                            imem_addr <= '0;
                            cpu_hold  <= 1'b1;
                        end else begin
                            // Empty load goes straight to FINISH, which releases the CPU.
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                ASSEMBLE: begin
                    if (accept) begin
                        shreg    <= {shreg[23:0], in_byte};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wdata <= {shreg[23:0], in_byte};
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt_inc;
                    byte_idx <= 2'd0;
                    if (last_word) begin
                        cpu_hold <= 1'b0;
                    end else begin
                        imem_addr <= imem_addr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table on a 7-bit-address instance,
// plus reset-mid-load and clamp/start-while-busy sequences on a 2-bit-address instance.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  word_count;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    logic        start2;
    logic [2:0]  wc2;
    logic [7:0]  byte2;
    logic        valid2;
    logic        ready2;
    logic        we2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic        hold2;
    logic        busy2;
    logic        done2;

    int n_cmp  = 0;
    int n_fail = 0;

    imem_loader #(.ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    imem_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .word_count(wc2),
        .in_byte(byte2), .in_valid(valid2), .in_ready(ready2),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .cpu_hold(hold2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    typedef struct {
        logic        s;
        logic [7:0]  wc;
        logic [7:0]  b;
        logic        v;
        logic [43:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [7:0] wc, input logic [7:0] b, input logic v,
                       input logic rdy, input logic we, input logic [6:0] a, input logic [31:0] wd,
                       input logic h, input logic bz, input logic d);
        vec_t r;
        r.s = s; r.wc = wc; r.b = b; r.v = v;
        r.exp = {rdy, we, a, wd, h, bz, d};
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [43:0] outs7();
        return {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done};
    endfunction

    // Byte stream driver and write monitor for the 7-bit instance, one call per cycle.
    logic [7:0]  bq[$];
    int          bi;
    logic [6:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          n_done;

    task automatic tick7();
        @(negedge clk);
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (done) n_done++;
        start = 1'b0;
        if (bi < bq.size()) begin
            in_byte  = bq[bi];
            in_valid = 1'b1;
            if (in_ready) bi++;
        end else begin
            in_byte  = 8'h00;
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [7:0] stream2(input int j);
        logic [7:0] pos;
        logic [7:0] k;
        pos = 8'(j % 4);
        k   = 8'(j / 4);
        return 8'hA0 + 8'h10 * pos + k;
    endfunction

    initial begin
        int          b2;
        int          done_cyc;
        int          last_wr_cyc;
        logic [1:0]  w2_addr[$];
        logic [31:0] w2_data[$];

        rst = 1'b1; start = 1'b0; word_count = 8'd0; in_byte = 8'd0; in_valid = 1'b0;
        start2 = 1'b0; wc2 = 3'd0; byte2 = 8'd0; valid2 = 1'b0;

        //     s  wc     byte   v   rdy we addr  wdata         hold busy done
        add(1, 8'd2, 8'h00, 0,  0, 0, 7'd0, 32'h0,        1, 0, 0);
        add(0, 8'd0, 8'h8C, 1,  1, 0, 7'd0, 32'h0,        1, 1, 0);
        add(0, 8'd0, 8'h01, 1,  1, 0, 7'd0, 32'h0,        1, 1, 0);
        add(0, 8'd0, 8'h00, 1,  1, 0, 7'd0, 32'h0,        1, 1, 0);
        add(0, 8'd0, 8'h04, 1,  1, 0, 7'd0, 32'h0,        1, 1, 0);
        add(0, 8'd0, 8'hAC, 1,  0, 1, 7'd0, 32'h8C010004, 1, 1, 0);
        add(0, 8'd0, 8'hAC, 1,  1, 0, 7'd1, 32'h8C010004, 1, 1, 0);
        add(1, 8'd5, 8'h02, 1,  1, 0, 7'd1, 32'h8C010004, 1, 1, 0);
        add(0, 8'd0, 8'h00, 1,  1, 0, 7'd1, 32'h8C010004, 1, 1, 0);
        add(0, 8'd0, 8'h08, 1,  1, 0, 7'd1, 32'h8C010004, 1, 1, 0);
        add(0, 8'd0, 8'h00, 0,  0, 1, 7'd1, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h00, 0,  0, 0, 7'd1, 32'hAC020008, 0, 0, 1);
        add(1, 8'd1, 8'h00, 0,  0, 0, 7'd1, 32'hAC020008, 0, 0, 0);
        add(0, 8'd0, 8'h8C, 1,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'hFF, 0,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'hEE, 0,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h01, 1,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h00, 1,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h33, 0,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h04, 1,  1, 0, 7'd0, 32'hAC020008, 1, 1, 0);
        add(0, 8'd0, 8'h00, 0,  0, 1, 7'd0, 32'h8C010004, 1, 1, 0);
        add(0, 8'd0, 8'h00, 0,  0, 0, 7'd0, 32'h8C010004, 0, 0, 1);
        add(1, 8'd0, 8'h00, 0,  0, 0, 7'd0, 32'h8C010004, 0, 0, 0);
        add(0, 8'd0, 8'h00, 0,  0, 0, 7'd0, 32'h8C010004, 0, 0, 1);
        add(0, 8'd0, 8'h00, 0,  0, 0, 7'd0, 32'h8C010004, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_after_reset%0d", i), 64'(outs7()),
                  64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(outs7()), 64'(vecs[i].exp));
            start      = vecs[i].s;
            word_count = vecs[i].wc;
            in_byte    = vecs[i].b;
            in_valid   = vecs[i].v;
        end

        // 3-word load reset after the second byte of the second word.
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        bi = 0; n_done = 0; wr_addr.delete(); wr_data.delete();
        @(negedge clk);
        start = 1'b1; word_count = 8'd3; in_valid = 1'b0;
        repeat (7) tick7();
        check("midload_bytes_taken", 64'(bi), 64'd6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_midload_outputs", 64'(outs7()),
              64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
        check("rst_midload_nwrites", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1)
            check("rst_midload_word0", 64'({wr_addr[0], wr_data[0]}), 64'({7'd0, 32'h11223344}));
        rst = 1'b0; in_valid = 1'b0;

        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bi = 0; n_done = 0; wr_addr.delete(); wr_data.delete();
        @(negedge clk);
        start = 1'b1; word_count = 8'd1;
        repeat (8) tick7();
        check("reload_nwrites", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1)
            check("reload_word", 64'({wr_addr[0], wr_data[0]}), 64'({7'd0, 32'hDEADBEEF}));
        check("reload_done_pulses", 64'(n_done), 64'd1);
        check("reload_hold_released", 64'(cpu_hold), 64'd0);

        // ADDR_W=2 instance: word_count=7 clamps to 4 words, start mid-load is ignored.
        b2 = 0; done_cyc = -1; last_wr_cyc = -1;
        @(negedge clk);
        start2 = 1'b1; wc2 = 3'd7;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (we2) begin
                w2_addr.push_back(addr2);
                w2_data.push_back(wdata2);
                last_wr_cyc = cyc;
            end
            if (done2 && done_cyc < 0) done_cyc = cyc;
            start2 = (cyc == 7);
            wc2    = (cyc == 7) ? 3'd1 : 3'd7;
            if (b2 < 24) begin
                byte2  = stream2(b2);
                valid2 = 1'b1;
                if (ready2) b2++;
            end else begin
                valid2 = 1'b0;
            end
            if (done_cyc >= 0 && cyc > done_cyc + 6) break;
        end
        start2 = 1'b0; valid2 = 1'b0;
        check("clamp_done_seen", 64'(done_cyc >= 0), 64'd1);
        check("clamp_nwrites", 64'(w2_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < w2_addr.size())
                check($sformatf("clamp_word%0d", i), 64'({w2_addr[i], w2_data[i]}),
                      64'({2'(i), 8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)}));
        end
        check("clamp_done_after_last_write", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("clamp_bytes_consumed", 64'(b2), 64'd16);
        check("clamp_final_state", 64'({addr2, hold2, busy2, ready2}), 64'({2'd3, 1'b0, 1'b0, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
